vga_rect_fill: RTL and testbench

Avalon-MM initiator that fills an axis-aligned rectangle by issuing one pixel-plot write per pixel to the VGA pixel port, in raster order. Software programs two corners and a brightness through a small Avalon-MM control port, then writes start. The block clips to the 160x120 screen, streams word-offset-0 writes with waitrequest back-pressure, and reports busy/done/count. It sits between the CPU bus and the VGA pixel port, offloading bulk fills from software.

---
 rtl/vga_pkg.sv | 30 +++
 rtl/rect_scan.sv | 56 +++++
 rtl/vga_rect_fill.sv | 188 ++++++++++++++++++
 tb/tb_vga_rect_fill.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared widths, pixel-word layout, control-port offsets and FSM states for
// the rectangle-fill initiator.
package vga_pkg;

  localparam int X_W        = 8;
  localparam int Y_W        = 7;
  localparam int CNT_W      = 15;
  localparam int Y_LSB      = 24;
  localparam int X_LSB      = 16;
  localparam int BRIGHT_LSB = 0;

  localparam logic [3:0] CORNER_A = 4'd0;
  localparam logic [3:0] CORNER_B = 4'd1;
  localparam logic [3:0] COLOUR   = 4'd2;
  localparam logic [3:0] CTRL     = 4'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    EMIT  = 2'd2
  } state_e;

  // Places a coordinate pair in the shared y/x word layout (corner registers and pixel words).
  function automatic logic [31:0] coord_word(input logic [Y_W-1:0] y, input logic [X_W-1:0] x);
    coord_word = 32'd0;
    coord_word[Y_LSB +: Y_W] = y;
    coord_word[X_LSB +: X_W] = x;
  endfunction

endpackage

// File: rtl/rect_scan.sv
// Raster-order x/y counter over a rectangle: load to the top-left corner,
// step one pixel at a time, flag the bottom-right pixel.
module rect_scan
  import vga_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  logic           step,
  input  logic [X_W-1:0] xmin,
  input  logic [X_W-1:0] xmax,
  input  logic [Y_W-1:0] ymin,
  input  logic [Y_W-1:0] ymax,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last
);

  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (load) begin
      x_d = xmin;
      y_d = ymin;
    end else if (step) begin
      if (x_q == xmax) begin
        x_d = xmin;
        y_d = y_q + Y_W'(1);
      end else begin
        x_d = x_q + X_W'(1);
        y_d = y_q;
      end
    end else begin
      x_d = x_q;
      y_d = y_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign last = (x_q == xmax) && (y_q == ymax);

endmodule

// File: rtl/vga_rect_fill.sv
// Avalon-MM rectangle filler: control registers, fill FSM and the pixel-port
// initiator that streams one write per clipped pixel in raster order.
module vga_rect_fill
  import vga_pkg::*;
#(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  address,
  input  logic        read,
  output logic [31:0] readdata,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [3:0]  m_address,
  output logic        m_write,
  output logic [31:0] m_writedata,
  input  logic        m_waitrequest
);

  localparam logic [X_W-1:0] X_LAST = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(SCREEN_H - 1);

  state_e           state_q, state_d;
  logic [X_W-1:0]   ax_q, ax_d, bx_q, bx_d;
  logic [Y_W-1:0]   ay_q, ay_d, by_q, by_d;
  logic [7:0]       bright_q, bright_d;
  logic             busy_q, busy_d, done_q, done_d, m_write_q, m_write_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [X_W-1:0] xlo, xhi_raw, xhi, scan_x;
  logic [Y_W-1:0] ylo, yhi_raw, yhi, scan_y;
  logic           empty, scan_load, scan_step, scan_last, wr_ok, start_s;
  logic           unused_wdata;

  // Corners cannot change while busy, so the clipped bounds stay valid through EMIT.
  assign xlo     = (ax_q < bx_q) ? ax_q : bx_q;
  assign xhi_raw = (ax_q < bx_q) ? bx_q : ax_q;
  assign ylo     = (ay_q < by_q) ? ay_q : by_q;
  assign yhi_raw = (ay_q < by_q) ? by_q : ay_q;
  assign xhi     = (xhi_raw > X_LAST) ? X_LAST : xhi_raw;
  assign yhi     = (yhi_raw > Y_LAST) ? Y_LAST : yhi_raw;
  assign empty   = (xlo > xhi) || (ylo > yhi);

  assign wr_ok   = write && !busy_q;
  assign start_s = wr_ok && (address == CTRL) && writedata[0];
  assign unused_wdata = &{1'b0, writedata[31], writedata[15:8]};

  rect_scan u_scan (
    .clk   (clk),
    .reset (reset),
    .load  (scan_load),
    .step  (scan_step),
    .xmin  (xlo),
    .xmax  (xhi),
    .ymin  (ylo),
    .ymax  (yhi),
    .x     (scan_x),
    .y     (scan_y),
    .last  (scan_last)
  );

  always_comb begin
    state_d   = state_q;
    ax_d      = ax_q;
    ay_d      = ay_q;
    bx_d      = bx_q;
    by_d      = by_q;
    bright_d  = bright_q;
    busy_d    = busy_q;
    done_d    = done_q;
    count_d   = count_q;
    m_write_d = m_write_q;
    scan_load = 1'b0;
    scan_step = 1'b0;

    if (wr_ok) begin
      case (address)
        CORNER_A: begin
          ay_d = writedata[Y_LSB +: Y_W];
          ax_d = writedata[X_LSB +: X_W];
        end
        CORNER_B: begin
          by_d = writedata[Y_LSB +: Y_W];
          bx_d = writedata[X_LSB +: X_W];
        end
        COLOUR:  bright_d = writedata[BRIGHT_LSB +: 8];
        default: ;
      endcase
    end else begin
      bright_d = bright_q;
    end

    case (state_q)
      IDLE: begin
        // busy still set in IDLE only on the empty-rectangle path: finish it here.
        if (busy_q) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end else if (start_s) begin
          busy_d  = 1'b1;
          done_d  = 1'b0;
          count_d = '0;
          state_d = SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        if (empty) begin
          state_d = IDLE;
        end else begin
          scan_load = 1'b1;
          m_write_d = 1'b1;
          state_d   = EMIT;
        end
      end
      EMIT: begin
        if (!m_waitrequest) begin
          count_d   = count_q + CNT_W'(1);
          scan_step = 1'b1;
          if (scan_last) begin
            m_write_d = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            state_d   = IDLE;
          end else begin
            state_d = EMIT;
          end
        end else begin
          state_d = EMIT;
        end
      end
      default: begin
        state_d   = IDLE;
        busy_d    = 1'b0;
        m_write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ax_q      <= '0;
      ay_q      <= '0;
      bx_q      <= '0;
      by_q      <= '0;
      bright_q  <= 8'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      count_q   <= '0;
      m_write_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ax_q      <= ax_d;
      ay_q      <= ay_d;
      bx_q      <= bx_d;
      by_q      <= by_d;
      bright_q  <= bright_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      count_q   <= count_d;
      m_write_q <= m_write_d;
    end
  end

  assign m_address   = 4'd0;
  assign m_write     = m_write_q;
  assign m_writedata = coord_word(scan_y, scan_x) | {24'd0, bright_q};

  always_comb begin
    readdata = 32'd0;
    if (read) begin
      case (address)
        CORNER_A: readdata = coord_word(ay_q, ax_q);
        CORNER_B: readdata = coord_word(by_q, bx_q);
        COLOUR:   readdata = {24'd0, bright_q};
        CTRL:     readdata = {1'b0, count_q, 14'd0, done_q, busy_q};
        default:  readdata = 32'd0;
      endcase
    end else begin
      readdata = 32'd0;
    end
  end

endmodule

// File: tb/tb_vga_rect_fill.sv
// Randomised scoreboard bench for vga_rect_fill: a rectangle model fills the
// expected-pixel queue, a monitor pops and compares every pixel-port transfer.
module tb_vga_rect_fill;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  address;
  logic        read;
  logic [31:0] readdata;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  m_address;
  logic        m_write;
  logic [31:0] m_writedata;
  logic        m_waitrequest;

  always #5 clk = ~clk;

  vga_rect_fill dut (
    .clk           (clk),
    .reset         (reset),
    .address       (address),
    .read          (read),
    .readdata      (readdata),
    .write         (write),
    .writedata     (writedata),
    .m_address     (m_address),
    .m_write       (m_write),
    .m_writedata   (m_writedata),
    .m_waitrequest (m_waitrequest)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_q[$];
  int          xfer_cnt = 0;
  int          stall_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Reference: every pixel of the clipped rectangle in raster order.
  function automatic int model_push(input int ax, input int ay, input int bx, input int by, input int br);
    int xl, xh, yl, yh, n;
    xl = (ax < bx) ? ax : bx;
    xh = (ax < bx) ? bx : ax;
    yl = (ay < by) ? ay : by;
    yh = (ay < by) ? by : ay;
    if (xh > 159) xh = 159;
    if (yh > 119) yh = 119;
    n = 0;
    for (int y = yl; y <= yh; y++)
      for (int x = xl; x <= xh; x++) begin
        exp_q.push_back({1'b0, 7'(y), 8'(x), 8'd0, 8'(br)});
        n++;
      end
    return n;
  endfunction

  // Pixel-port back-pressure: none, 50% random, or stall from the third pixel on.
  initial begin
    m_waitrequest = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (stall_mode)
        1:       m_waitrequest = 1'($urandom_range(0, 1));
        2:       m_waitrequest = (xfer_cnt >= 2);
        default: m_waitrequest = 1'b0;
      endcase
    end
  end

  // Monitor: stall stability and scoreboard pops on each transfer.
  initial begin
    logic        prev_stall;
    logic [31:0] prev_word;
    logic [31:0] e;
    prev_stall = 1'b0;
    prev_word  = 32'd0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_hold_write", {31'd0, m_write}, 32'd1);
          check("stall_hold_word", m_writedata, prev_word);
        end
        if (m_write) begin
          check("m_address", {28'd0, m_address}, 32'd0);
          if (!m_waitrequest) begin
            xfer_cnt++;
            if (exp_q.size() == 0) begin
              n_checks++;
              $display("FAIL unexpected_pixel: got 0x%08h expected no transfer", m_writedata);
            end else begin
              e = exp_q.pop_front();
              check("pixel_word", m_writedata, e);
            end
          end
        end
        prev_stall = m_write && m_waitrequest;
        prev_word  = m_writedata;
      end
    end
  end

  task automatic ctrl_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    address   = a;
    writedata = d;
    write     = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic ctrl_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic run_fill(input int ax, input int ay, input int bx, input int by, input int br,
                          input int mode, input bit poke);
    int          n;
    bit          seen_done;
    logic [31:0] r, ca;
    stall_mode = mode;
    ca = {1'b0, 7'(ay), 8'(ax), 16'd0};
    ctrl_write(4'd0, ca);
    ctrl_write(4'd1, {1'b0, 7'(by), 8'(bx), 16'd0});
    ctrl_write(4'd2, {24'd0, 8'(br)});
    ctrl_read(4'd0, r);
    check("rd_corner_a", r, ca);
    ctrl_read(4'd2, r);
    check("rd_colour", r, {24'd0, 8'(br)});
    xfer_cnt = 0;
    n = model_push(ax, ay, bx, by, br);
    ctrl_write(4'd3, 32'd1);
    #1;
    check("setup_busy_done", {30'd0, readdata[1:0]}, 32'd1);
    check("setup_no_write", {31'd0, m_write}, 32'd0);
    @(negedge clk);
    #1;
    if (n == 0) begin
      check("empty_busy2", {30'd0, readdata[1:0]}, 32'd1);
      check("empty_no_write", {31'd0, m_write}, 32'd0);
      @(negedge clk);
      #1;
      check("empty_status", readdata, 32'h0000_0002);
    end else begin
      check("first_write_t2", {31'd0, m_write}, 32'd1);
      check("first_busy", {31'd0, readdata[0]}, 32'd1);
      if (poke) begin
        ctrl_write(4'd0, 32'h7F7F_0000);
        ctrl_write(4'd2, 32'h0000_0011);
        address = 4'd3;
      end
      seen_done = 1'b0;
      for (int i = 0; i < 5000 && !seen_done; i++) begin
        @(negedge clk);
        #1;
        if (readdata[1]) seen_done = 1'b1;
      end
      if (!seen_done) begin
        n_checks++;
        $display("FAIL done_timeout: got no done expected done within 5000 cycles");
      end
      check("final_status", readdata, {1'b0, 15'(n), 14'd0, 1'b1, 1'b0});
      check("xfer_count", 32'(xfer_cnt), 32'(n));
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    if (poke) begin
      ctrl_read(4'd0, r);
      check("poke_corner_kept", r, ca);
      ctrl_read(4'd2, r);
      check("poke_colour_kept", r, {24'd0, 8'(br)});
    end
    stall_mode = 0;
  endtask

  initial begin
    logic [31:0] r;
    int ax, ay, bx, by, t;
    reset = 1'b1; address = 4'd0; read = 1'b1; write = 1'b0; writedata = 32'd0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_m_write", {31'd0, m_write}, 32'd0);
    check("rst_m_wdata", m_writedata, 32'd0);
    check("rst_m_addr", {28'd0, m_address}, 32'd0);
    for (int a = 0; a < 4; a++) begin
      address = 4'(a);
      #1;
      check("rst_readdata", readdata, 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;

    run_fill(2, 3, 4, 4, 8'hFF, 0, 1'b0);
    run_fill(4, 4, 2, 3, 8'hFF, 0, 1'b0);
    run_fill(155, 117, 200, 127, 8'h5A, 1, 1'b0);
    run_fill(170, 5, 180, 9, 8'h33, 0, 1'b0);
    run_fill(20, 30, 22, 32, 8'hA5, 1, 1'b1);

    // Reset while the third pixel is stalled.
    xfer_cnt = 0;
    stall_mode = 2;
    ctrl_write(4'd0, {1'b0, 7'd10, 8'd10, 16'd0});
    ctrl_write(4'd1, {1'b0, 7'd12, 8'd12, 16'd0});
    ctrl_write(4'd2, 32'h0000_0077);
    t = model_push(10, 10, 12, 12, 8'h77);
    ctrl_write(4'd3, 32'd1);
    for (int i = 0; i < 100 && !(m_write && m_waitrequest); i++) begin
      @(negedge clk);
      #1;
    end
    check("stall_before_reset", {30'd0, m_write, m_waitrequest}, 32'd3);
    check("xfers_before_reset", 32'(xfer_cnt), 32'd2);
    reset = 1'b1;
    #1;
    check("async_drop_write", {31'd0, m_write}, 32'd0);
    check("reset_m_wdata", m_writedata, 32'd0);
    for (int a = 0; a < 4; a++) begin
      address = 4'(a);
      #1;
      check("reset_readdata", readdata, 32'd0);
    end
    exp_q.delete();
    stall_mode = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    run_fill(10, 10, 12, 12, 8'h77, 0, 1'b0);

    for (int k = 0; k < 6; k++) begin
      ax = $urandom_range(0, 165);
      ay = $urandom_range(0, 124);
      bx = ax + $urandom_range(0, 6);
      by = ay + $urandom_range(0, 4);
      if (by > 127) by = 127;
      if ($urandom_range(0, 1) == 1) run_fill(bx, by, ax, ay, $urandom_range(0, 255), 1, 1'b0);
      else run_fill(ax, ay, bx, by, $urandom_range(0, 255), 1, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
